// File: rtl/learn_costs_if.sv
// Neighbor-table memory bus shared by learn_costs (master) and the 2048 x 16 table (slave).
interface learn_costs_if;
   logic [10:0] address;
   logic        wr_en;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out;

   modport master (
      output address,
      output wr_en,
      output mem_data_in,
      input  mem_data_out
   );

   modport slave (
      input  address,
      input  wr_en,
      input  mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/learn_costs.sv
// Learns a neighbor's costs: searches the neighbor table for the ID and updates the
// entry in place, or appends a new entry when the ID is absent and the table has room.
module learn_costs (
   input  logic          clock,
   input  logic          nrst,
   input  logic          en,
   input  logic [15:0]   fsourceID,
   input  logic [15:0]   fbatteryStat,
   input  logic [15:0]   fValue,
   input  logic [15:0]   fclusterID,
   input  logic [15:0]   initial_epsilon,
   learn_costs_if.master mem,
   output logic          done
);

   typedef enum logic [3:0] {
      StIdle, StRdCnt, StWaitCnt, StRdId, StWaitId, StCmp,
      StWrBat, StWrVal, StWrClu, StWrId, StWrEps, StWrCnt, StDone
   } state_e;

   localparam logic [4:0] MaxEntries = 5'd16;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;   // entry being searched, or slot being appended
   logic [4:0]  cnt_q, cnt_d;   // neighbor count N, clamped to 16
   logic        new_q, new_d;   // current write sequence appends a new entry
   logic [15:0] id_q, id_d;
   logic [15:0] bat_q, bat_d;
   logic [15:0] val_q, val_d;
   logic [15:0] clu_q, clu_d;
   logic [15:0] eps_q, eps_d;
   logic [10:0] base;

   assign base = 11'h010 + {4'b0000, idx_q, 3'b000};

   // State and operand registers; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         new_q   <= 1'b0;
         id_q    <= '0;
         bat_q   <= '0;
         val_q   <= '0;
         clu_q   <= '0;
         eps_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         new_q   <= new_d;
         id_q    <= id_d;
         bat_q   <= bat_d;
         val_q   <= val_d;
         clu_q   <= clu_d;
         eps_q   <= eps_d;
      end
   end

   // Next-state logic and Moore outputs; bus is idle (all zero) outside the active states.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      cnt_d           = cnt_q;
      new_d           = new_q;
      id_d            = id_q;
      bat_d           = bat_q;
      val_d           = val_q;
      clu_d           = clu_q;
      eps_d           = eps_q;
      mem.address     = '0;
      mem.wr_en       = 1'b0;
      mem.mem_data_in = '0;
      done            = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en) begin
               id_d    = fsourceID;
               bat_d   = fbatteryStat;
               val_d   = fValue;
               clu_d   = fclusterID;
               eps_d   = initial_epsilon;
               idx_d   = '0;
               new_d   = 1'b0;
               state_d = StRdCnt;
            end
         end
         StRdCnt: state_d = StWaitCnt;
         StWaitCnt: begin
            // Out-of-range counts are treated as a full table.
            cnt_d = (mem.mem_data_out > 16'd16) ? MaxEntries : mem.mem_data_out[4:0];
            if (mem.mem_data_out == 16'd0) begin
               new_d   = 1'b1;
               state_d = StWrId;
            end else begin
               state_d = StRdId;
            end
         end
         StRdId: begin
            mem.address = base;
            state_d     = StWaitId;
         end
         StWaitId: begin
            mem.address = base;
            state_d     = StCmp;
         end
         StCmp: begin
            mem.address = base;
            if (mem.mem_data_out == id_q) begin
               state_d = StWrBat;
            end else if (({1'b0, idx_q} + 5'd1) < cnt_q) begin
               idx_d   = idx_q + 4'd1;
               state_d = StRdId;
            end else if (cnt_q < MaxEntries) begin
               idx_d   = cnt_q[3:0];
               new_d   = 1'b1;
               state_d = StWrId;
            end else begin
               state_d = StDone;
            end
         end
         StWrId: begin
            mem.address     = base;
            mem.wr_en       = 1'b1;
            mem.mem_data_in = id_q;
            state_d         = StWrBat;
         end
         StWrBat: begin
            mem.address     = base + 11'd1;
            mem.wr_en       = 1'b1;
            mem.mem_data_in = bat_q;
            state_d         = StWrVal;
         end
         StWrVal: begin
            mem.address     = base + 11'd2;
            mem.wr_en       = 1'b1;
            mem.mem_data_in = val_q;
            state_d         = StWrClu;
         end
         StWrClu: begin
            mem.address     = base + 11'd3;
            mem.wr_en       = 1'b1;
            mem.mem_data_in = clu_q;
            state_d         = new_q ? StWrEps : StDone;
         end
         StWrEps: begin
            mem.address     = base + 11'd4;
            mem.wr_en       = 1'b1;
            mem.mem_data_in = eps_q;
            state_d         = StWrCnt;
         end
         StWrCnt: begin
            mem.address     = 11'h000;
            mem.wr_en       = 1'b1;
            mem.mem_data_in = {11'b0, cnt_q + 5'd1};
            state_d         = StDone;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_learn_costs.sv
// Bench for learn_costs: behavioural table memory, directed cases and randomized tables
// checked against a search/update model of the neighbor table.
module tb_learn_costs;

   logic        clock;
   logic        nrst;
   logic        en;
   logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon;
   logic        done;

   learn_costs_if bus();

   learn_costs dut (
      .clock           (clock),
      .nrst            (nrst),
      .en              (en),
      .fsourceID       (fsourceID),
      .fbatteryStat    (fbatteryStat),
      .fValue          (fValue),
      .fclusterID      (fclusterID),
      .initial_epsilon (initial_epsilon),
      .mem             (bus),
      .done            (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Table memory: synchronous write, registered read, plus a preload port for the bench.
   logic [15:0] mem [0:2047];
   logic [15:0] rd_q;
   logic        pl_we;
   logic [10:0] pl_addr;
   logic [15:0] pl_data;

   always @(posedge clock) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (bus.wr_en) mem[bus.address] <= bus.mem_data_in;
      rd_q <= mem[bus.address];
   end
   assign bus.mem_data_out = rd_q;

   int unsigned done_cnt = 0;
   int unsigned wr_cnt   = 0;
   always @(posedge clock) begin
      if (done) done_cnt <= done_cnt + 1;
      if (bus.wr_en) wr_cnt <= wr_cnt + 1;
   end

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_mem [0:255];
   int          exp_writes;
   logic [15:0] ids [0:15];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic poke(input logic [10:0] a, input logic [15:0] d);
      @(negedge clock);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
   endtask

   task automatic poke_end();
      @(negedge clock);
      pl_we = 1'b0;
   endtask

   // Count word plus n entries with IDs from ids[] and random other fields.
   task automatic load_table(input int n);
      poke(11'h000, 16'(n));
      for (int i = 0; i < n; i++) begin
         poke(11'(16 + 8 * i), ids[i]);
         for (int k = 1; k < 5; k++) poke(11'(16 + 8 * i + k), 16'($urandom));
      end
      poke_end();
   endtask

   // Expected table after one operation: first matching ID is updated, else append if room.
   task automatic model(input logic [15:0] id, bat, val, clu, eps, output int n0);
      int n;
      int hit;
      int b;
      for (int a = 0; a < 256; a++) exp_mem[a] = mem[a];
      n   = int'(exp_mem[0]);
      n0  = n;
      hit = -1;
      for (int i = 0; i < n && hit < 0; i++) if (exp_mem[16 + 8 * i] == id) hit = i;
      if (hit >= 0) begin
         b = 16 + 8 * hit;
         exp_mem[b + 1] = bat;
         exp_mem[b + 2] = val;
         exp_mem[b + 3] = clu;
         exp_writes = 3;
      end else if (n < 16) begin
         b = 16 + 8 * n;
         exp_mem[b]     = id;
         exp_mem[b + 1] = bat;
         exp_mem[b + 2] = val;
         exp_mem[b + 3] = clu;
         exp_mem[b + 4] = eps;
         exp_mem[0]     = 16'(n + 1);
         exp_writes = 6;
      end else begin
         exp_writes = 0;
      end
   endtask

   task automatic run_op(input logic [15:0] id, bat, val, clu, eps, input bit dbl,
                         input string tag);
      int          n;
      int unsigned d0, w0;
      bit          seen;
      int          bad;
      model(id, bat, val, clu, eps, n);
      d0 = done_cnt;
      w0 = wr_cnt;
      @(negedge clock);
      en = 1'b1;
      fsourceID = id; fbatteryStat = bat; fValue = val; fclusterID = clu; initial_epsilon = eps;
      @(negedge clock);
      en = 1'b0;
      // Inputs change after the start; the operation must use the latched values.
      fsourceID = 16'($urandom); fbatteryStat = 16'($urandom); fValue = 16'($urandom);
      fclusterID = 16'($urandom); initial_epsilon = 16'($urandom);
      seen = 1'b0;
      for (int it = 1; it <= 3 * n + 12 && !seen; it++) begin
         @(negedge clock);
         en = dbl && (it == 1);
         if (done) seen = 1'b1;
      end
      en = 1'b0;
      check({tag, "_done_in_time"}, 32'(seen), 32'd1);
      @(negedge clock);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      repeat (4) @(negedge clock);
      check({tag, "_done_count"}, done_cnt - d0, 32'd1);
      check({tag, "_write_count"}, wr_cnt - w0, 32'(exp_writes));
      bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
      check({tag, "_table_words_wrong"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int unsigned d0;
      logic [15:0] old22;
      bit          hit;
      nrst = 1'b0; en = 1'b0;
      fsourceID = '0; fbatteryStat = '0; fValue = '0; fclusterID = '0; initial_epsilon = '0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      #1;
      check("rst_address", 32'(bus.address), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_data_in", 32'(bus.mem_data_in), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      for (int a = 0; a < 256; a++) poke(11'(a), 16'h0000);
      poke_end();
      nrst = 1'b1;

      // Update of an existing entry.
      ids[0] = 16'd7; ids[1] = 16'd31;
      load_table(2);
      run_op(16'd31, 16'd5, 16'd10, 16'd11, 16'd1, 1'b0, "match");
      check("match_bat", 32'(mem[11'h019]), 32'd5);
      check("match_val", 32'(mem[11'h01A]), 32'd10);
      check("match_clu", 32'(mem[11'h01B]), 32'd11);
      check("match_count", 32'(mem[11'h000]), 32'd2);

      // Append behind two entries.
      load_table(2);
      run_op(16'd1, 16'd5, 16'd10, 16'd11, 16'd1, 1'b0, "append");
      check("append_id", 32'(mem[11'h020]), 32'd1);
      check("append_eps", 32'(mem[11'h024]), 32'd1);
      check("append_count", 32'(mem[11'h000]), 32'd3);

      // Empty table.
      load_table(0);
      run_op(16'd9, 16'd2, 16'd3, 16'd4, 16'd5, 1'b0, "empty");
      check("empty_id", 32'(mem[11'h010]), 32'd9);
      check("empty_count", 32'(mem[11'h000]), 32'd1);

      // Full table with no match.
      for (int i = 0; i < 16; i++) ids[i] = 16'(100 + i);
      load_table(16);
      run_op(16'd1, 16'd5, 16'd10, 16'd11, 16'd1, 1'b0, "full");
      check("full_count", 32'(mem[11'h000]), 32'd16);

      // Full table, match in the last entry.
      run_op(16'd115, 16'd6, 16'd7, 16'd8, 16'd9, 1'b0, "full_last");

      // Duplicate IDs: only the first is updated.
      ids[0] = 16'd5; ids[1] = 16'd5;
      load_table(2);
      run_op(16'd5, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'd1, 1'b0, "dup");

      // Second start request while busy is dropped.
      ids[0] = 16'd7; ids[1] = 16'd31;
      load_table(2);
      run_op(16'd31, 16'd5, 16'd10, 16'd11, 16'd1, 1'b1, "double_en");

      // Randomized tables with small ID space so matches and duplicates occur.
      for (int t = 0; t < 20; t++) begin
         int n;
         n = int'($urandom_range(0, 16));
         for (int i = 0; i < 16; i++) ids[i] = 16'($urandom_range(0, 20));
         load_table(n);
         run_op(16'($urandom_range(0, 20)), 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
      end

      // Reset while the value word of an append is being written.
      ids[0] = 16'd7; ids[1] = 16'd31;
      load_table(2);
      old22 = mem[11'h022];
      @(negedge clock);
      en = 1'b1;
      fsourceID = 16'd1; fbatteryStat = 16'd5; fValue = 16'd10; fclusterID = 16'd11;
      initial_epsilon = 16'd1;
      @(negedge clock);
      en = 1'b0;
      hit = 1'b0;
      for (int it = 0; it < 40 && !hit; it++) begin
         @(negedge clock);
         if (bus.wr_en && bus.address == 11'h022) hit = 1'b1;
      end
      check("abort_reached_value_write", 32'(hit), 32'd1);
      d0 = done_cnt;
      #2 nrst = 1'b0;
      #1;
      check("abort_address", 32'(bus.address), 32'd0);
      check("abort_wr_en", 32'(bus.wr_en), 32'd0);
      check("abort_data_in", 32'(bus.mem_data_in), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (3) @(negedge clock);
      check("abort_count", 32'(mem[11'h000]), 32'd2);
      check("abort_value_untouched", 32'(mem[11'h022]), 32'(old22));
      check("abort_id_kept", 32'(mem[11'h020]), 32'd1);
      check("abort_bat_kept", 32'(mem[11'h021]), 32'd5);
      nrst = 1'b1;
      repeat (20) @(negedge clock);
      check("abort_no_done", done_cnt - d0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/learn_costs.md
LEARN_COSTS -- requirements
Module: learn_costs

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 nrst  input  1  reset, asynchronous, active-low.
REQ-003 en  input  1  start request; sampled only in IDLE; one-cycle pulse sufficient.
REQ-004 fsourceID  input  16  neighbor node ID being learned.
REQ-005 fbatteryStat  input  16  neighbor battery status.
REQ-006 fValue  input  16  neighbor cost value.
REQ-007 fclusterID  input  16  neighbor cluster ID.
REQ-008 initial_epsilon  input  16  epsilon stored for a newly added neighbor.
REQ-009 address  output  11  word address to neighbor-table memory.
REQ-010 wr_en  output  1  memory write strobe; write occurs at the rising edge where wr_en=1.
REQ-011 mem_data_out  input  16  memory read data; valid one cycle after address is presented (synchronous read).
REQ-012 mem_data_in  output  16  memory write data.
REQ-013 done  output  1  one-cycle pulse when the update completes.
REQ-014 The companion memory SHALL have 2048 x 16-bit words, synchronous write and registered read, no reset of contents.

Function
REQ-015 Memory map SHALL be: word 0x000 = neighbor count N (0..16); entry i at base B=0x010+8*i; B+0 ID, B+1 battery, B+2 value, B+3 clusterID, B+4 epsilon.
REQ-016 On en=1 in IDLE, all five data inputs SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-017 FSM states SHALL be: IDLE, RD_CNT, WAIT_CNT, RD_ID, WAIT_ID, CMP, WR_BAT, WR_VAL, WR_CLU, WR_ID, WR_EPS, WR_CNT, DONE.
REQ-018 RD_CNT/WAIT_CNT SHALL read N from 0x000; the search index i SHALL start at 0.
REQ-019 For each i<N: RD_ID presents B+0, WAIT_ID waits, CMP compares all 16 bits of read data to latched fsourceID.
REQ-020 On match: WR_BAT, WR_VAL, WR_CLU SHALL write battery, value, clusterID to B+1..B+3 in three consecutive cycles; ID, epsilon and N SHALL be unchanged; then DONE.
REQ-021 On mismatch with i+1<N: i increments, return to RD_ID.
REQ-022 Search exhausted (including N=0) with N<16: write WR_ID, WR_BAT, WR_VAL, WR_CLU, WR_EPS to entry N (ID, battery, value, cluster, initial_epsilon), then WR_CNT writes N+1 to 0x000, then DONE.
REQ-023 Search exhausted with N=16 (table full): no memory write; go directly to DONE.
REQ-024 Only the first matching entry SHALL be updated.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE; wr_en SHALL be 0 in every state other than the WR_* states.
REQ-026 en asserted while not in IDLE SHALL be ignored (not queued).
REQ-027 done SHALL be asserted no later than 3*N+12 cycles after the en-sampling edge.

Reset
REQ-028 nrst=0 SHALL immediately force state IDLE, address=0, wr_en=0, mem_data_in=0, done=0, index and latched inputs to 0.
REQ-029 Reset mid-operation SHALL abort without further writes; writes already performed remain in memory; memory contents are not cleared.

Verification
REQ-030 Preload N=2, entry0 ID=7, entry1 ID=31; en with fsourceID=31, battery=5, value=10, cluster=11, epsilon=1 -> 0x019=5, 0x01A=10, 0x01B=11, 0x000 stays 2, done one pulse.
REQ-031 Same preload, fsourceID=1 -> 0x020..0x024 = 1,5,10,11,1; 0x000=3; entries 0 and 1 unchanged.
REQ-032 Preload N=0, fsourceID=9 -> entry at 0x010 written, 0x000=1.
REQ-033 Preload N=16 with IDs 100..115, fsourceID=1 -> no wr_en pulse, memory unchanged, done pulses.
REQ-034 Second en pulse two cycles after first -> only one operation, one done pulse.
REQ-035 nrst low during WR_VAL of the REQ-031 case -> outputs at reset values immediately, 0x000 still 2, no done.
